// File: rtl/pipe_reg_elastic.sv
// Elastic valid/ready pipeline register for inter-stage boundaries of the core.
// Optional skid entry gives a registered in_ready; stall_cnt counts back-pressured cycles.
module pipe_reg_elastic #(
   parameter int WIDTH    = 32,
   parameter int SKID     = 1,
   parameter int CLR_DATA = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_q;

   generate
      if (SKID != 0) begin : g_skid
         state_t           state_q, state_d;
         logic [WIDTH-1:0] main_q, skid_q;
         logic             in_ready_q;
         logic             load_main_in, load_main_skid, load_skid;

         // State encoding doubles as the occupancy count.
         always_comb begin
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            case (state_q)
               ST_EMPTY: begin
                  if (in_valid) begin
                     load_main_in = 1'b1;
                     state_d      = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (in_valid && out_ready) begin
                     load_main_in = 1'b1;
                  end else if (in_valid) begin
                     load_skid = 1'b1;
                     state_d   = ST_FULL;
                  end else if (out_ready) begin
                     state_d = ST_EMPTY;
                  end
               end
               ST_FULL: begin
                  if (out_ready) begin
                     load_main_skid = 1'b1;
                     state_d        = ST_ONE;
                  end
               end
               default: state_d = ST_EMPTY;
            endcase
         end

         // in_ready is precomputed from the next state so it never sees out_ready combinationally.
         always_ff @(posedge clk) begin
            if (reset || flush) begin
               state_q    <= ST_EMPTY;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               in_ready_q <= (state_d != ST_FULL);
            end
         end

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               if (CLR_DATA != 0) begin
                  main_q <= '0;
                  skid_q <= '0;
               end
            end else begin
               if (load_main_in) begin
                  main_q <= in_data;
               end else if (load_main_skid) begin
                  main_q <= skid_q;
               end
               if (load_skid) begin
                  skid_q <= in_data;
               end
            end
         end

         assign in_ready  = in_ready_q;
         assign out_valid = (state_q != ST_EMPTY);
         assign occupancy = state_q;
         assign out_data  = main_q;
      end else begin : g_noskid
         logic             valid_q;
         logic [WIDTH-1:0] main_q;
         logic             in_xfer;

         assign in_ready = !valid_q || out_ready;
         assign in_xfer  = in_valid && in_ready;

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= in_xfer || (valid_q && !out_ready);
            end
         end

         always_ff @(posedge clk) begin
            if (reset || flush) begin
               if (CLR_DATA != 0) begin
                  main_q <= '0;
               end
            end else if (in_xfer) begin
               main_q <= in_data;
            end
         end

         assign out_valid = valid_q;
         assign occupancy = {1'b0, valid_q};
         assign out_data  = main_q;
      end
   endgenerate

   // Saturating back-pressure counter; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;

endmodule
